// File: rtl/irq_gate_pkg.sv
// Shared constants and types for the irq_gate interrupt conditioner.
// Optional level-trigger support is enabled with IRQ_GATE_LEVEL_MODE_EN.
package irq_gate_pkg;

    localparam int IRQ_NLINES      = 7;
    localparam int IRQ_HOLDOFF_W   = 4;
    localparam int IRQ_HOLDOFF_DEF = 4;

    typedef logic [IRQ_NLINES-1:0]    irq_vec_t;
    typedef logic [IRQ_HOLDOFF_W-1:0] irq_cnt_t;

endpackage

// File: rtl/irq_gate_line.sv
// One request line: sync chain, edge detect, hold-off counter,
// pending and sticky overrun.
module irq_gate_line
    import irq_gate_pkg::*;
#(
    parameter int HOLDOFF_W = IRQ_HOLDOFF_W,
    parameter int HOLDOFF   = IRQ_HOLDOFF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic mask,
    input  logic mask_clr,
    input  logic clr,
    input  logic level,
    output logic pulse,
    output logic pending,
    output logic overrun
);

    localparam logic [HOLDOFF_W-1:0] LOAD = HOLDOFF_W'(HOLDOFF);

    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic [HOLDOFF_W-1:0] cnt;
    logic                 edge_hit;
    logic                 idle;
    logic                 fire;

    // Level lines ignore the previous sample, so a held level re-fires.
    assign edge_hit = s2 & (level | ~s3) & mask;
    assign idle     = (cnt == '0);
    assign fire     = (edge_hit | pending) & idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            s3    <= s2;
            pulse <= fire;

            if (fire) begin
                cnt <= LOAD;
            end else if (!idle) begin
                cnt <= cnt - 1'b1;
            end

            if (mask_clr || fire) begin
                pending <= 1'b0;
            end else if (edge_hit && !idle) begin
                pending <= 1'b1;
            end

            // A new overrun beats a simultaneous clear.
            if (edge_hit && pending) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_gate.sv
// Interrupt source conditioner feeding the round-robin IRQ collector.
// Define IRQ_GATE_LEVEL_MODE_EN to add per-line level triggering.
module irq_gate
    import irq_gate_pkg::*;
#(
    parameter int                NLINES    = IRQ_NLINES,
    parameter int                HOLDOFF_W = IRQ_HOLDOFF_W,
    parameter int                HOLDOFF   = IRQ_HOLDOFF_DEF,
    parameter logic [NLINES-1:0] MASK_RST  = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NLINES-1:0] irq_raw,
`ifdef IRQ_GATE_LEVEL_MODE_EN
    input  logic [NLINES-1:0] level_sel,
`endif
    input  logic              mask_wr,
    input  logic [NLINES-1:0] mask_data,
    input  logic              clr_wr,
    input  logic [NLINES-1:0] clr_data,
    output logic [NLINES-1:0] irq_pulse,
    output logic [NLINES-1:0] irq_mask,
    output logic [NLINES-1:0] irq_pending,
    output logic [NLINES-1:0] overrun
);

    logic [NLINES-1:0] mask_q;
    logic [NLINES-1:0] level_q;
    logic [NLINES-1:0] mask_clr;
    logic [NLINES-1:0] clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= MASK_RST;
        end else if (mask_wr) begin
            mask_q <= mask_data;
        end
    end

`ifdef IRQ_GATE_LEVEL_MODE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_sel;
        end
    end
`else
    assign level_q = '0;
`endif

    // Disabling a line drops any deferred pulse it was holding.
    assign mask_clr = {NLINES{mask_wr}} & ~mask_data;
    assign clr      = {NLINES{clr_wr}} & clr_data;
    assign irq_mask = mask_q;

    for (genvar i = 0; i < NLINES; i++) begin : g_line
        irq_gate_line #(
            .HOLDOFF_W (HOLDOFF_W),
            .HOLDOFF   (HOLDOFF)
        ) u_line (
            .clk      (clk),
            .rst      (rst),
            .raw      (irq_raw[i]),
            .mask     (mask_q[i]),
            .mask_clr (mask_clr[i]),
            .clr      (clr[i]),
            .level    (level_q[i]),
            .pulse    (irq_pulse[i]),
            .pending  (irq_pending[i]),
            .overrun  (overrun[i])
        );
    end

endmodule
